ics2115_voice_engine: RTL and testbench

- Parametrised multi-voice PCM wavetable engine for the PGM audio subsystem; generalises the single-voice ICS2115 playback path.
- Up to NUM_VOICES voices, each with start/end/loop addresses, 8.8 fractional pitch step, per-voice L/R volume and loop mode.
- On each sample_tick, services every voice through the shared 64-bit SDRAM read port (per-voice one-word cache), mixes to saturated 16-bit stereo and pulses sample_valid.

---
 rtl/ics2115_voice_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ics2115_voice_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ics2115_voice_engine.sv
// Multi-voice PCM wavetable engine: each sample_tick walks every voice, fetches its 4-sample
// SDRAM word on a cache miss, scales by L/R volume and publishes a saturated stereo mix.
module ics2115_voice_engine #(
  parameter int          NUM_VOICES = 8,
  parameter int          ADDR_W     = 24,
  parameter logic [28:0] SDRAM_BASE = 29'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        we,
  input  logic        re,
  input  logic        sample_tick,
  output logic        sdram_rd,
  output logic [28:0] sdram_addr,
  input  logic [63:0] sdram_dout,
  input  logic        sdram_busy,
  input  logic        sdram_dout_ready,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid,
  output logic        overrun
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AW = 16 + VW + 1;
  localparam int PW = ADDR_W + 8;
  localparam int TW = ADDR_W - 2;
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

  // state | meaning
  // IDLE  | waiting for sample_tick
  // SCAN  | check run flag and cache tag of voice v
  // REQ   | SDRAM fetch of the 4-sample word under the voice position
  // MIX   | scale and accumulate the sample, advance the position
  // OUT   | saturate and publish the mix
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_MIX, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [VW-1:0]        v_q, v_d;
  logic signed [AW-1:0] accl_q, accl_d, accr_q, accr_d;
  logic [15:0]          sl_q, sl_d, sr_q, sr_d;
  logic                 valid_q, valid_d, ovr_q, ovr_d, rd_q, rd_d;
  logic [28:0]          addr_q, addr_d;
  logic [7:0]           sel_q, sel_d, idx_q, idx_d, hold_q, hold_d;

  logic [NUM_VOICES-1:0] run_q, run_d, loop_q, loop_d, done_q, done_d, cval_q, cval_d;
  logic [ADDR_W-1:0]     start_q [NUM_VOICES];
  logic [ADDR_W-1:0]     start_d [NUM_VOICES];
  logic [ADDR_W-1:0]     end_q   [NUM_VOICES];
  logic [ADDR_W-1:0]     end_d   [NUM_VOICES];
  logic [ADDR_W-1:0]     lpa_q   [NUM_VOICES];
  logic [ADDR_W-1:0]     lpa_d   [NUM_VOICES];
  logic [15:0]           step_q  [NUM_VOICES];
  logic [15:0]           step_d  [NUM_VOICES];
  logic [15:0]           vol_q   [NUM_VOICES];
  logic [15:0]           vol_d   [NUM_VOICES];
  logic [PW-1:0]         pos_q   [NUM_VOICES];
  logic [PW-1:0]         pos_d   [NUM_VOICES];
  logic [TW-1:0]         tag_q   [NUM_VOICES];
  logic [TW-1:0]         tag_d   [NUM_VOICES];
  logic [63:0]           word_q  [NUM_VOICES];
  logic [63:0]           word_d  [NUM_VOICES];

  logic [ADDR_W-1:0]    cur_int;
  logic [1:0]           lane;
  logic signed [15:0]   smp;
  logic signed [AW+7:0] smp_x, vl_x, vr_x, prod_l, prod_r;
  logic [PW:0]          sum;
  logic [28:0]          off;
  logic [VW-1:0]        hv;
  logic                 hv_ok;
  logic [15:0]          wdata, rval;
  logic                 unused_ok;

  function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
    if (a[AW-1:15] == {(AW-15){a[AW-1]}}) return a[15:0];
    return a[AW-1] ? 16'h8000 : 16'h7FFF;
  endfunction

  assign hv        = sel_q[VW-1:0];
  assign hv_ok     = (int'(hv) < NUM_VOICES) && (idx_q <= 8'd8);
  assign wdata     = {din, hold_q};
  assign unused_ok = ^{re, prod_l[7:0], prod_r[7:0]};

  always_comb begin
    rval = '0;
    if (hv_ok) begin
      case (idx_q[3:0])
        4'd0:    rval = {13'd0, done_q[hv], loop_q[hv], run_q[hv]};
        4'd1:    rval = 16'(start_q[hv][ADDR_W-1:16]);
        4'd2:    rval = start_q[hv][15:0];
        4'd3:    rval = 16'(end_q[hv][ADDR_W-1:16]);
        4'd4:    rval = end_q[hv][15:0];
        4'd5:    rval = 16'(lpa_q[hv][ADDR_W-1:16]);
        4'd6:    rval = lpa_q[hv][15:0];
        4'd7:    rval = step_q[hv];
        4'd8:    rval = vol_q[hv];
        default: rval = '0;
      endcase
    end
  end

  always_comb begin
    case (addr)
      2'd0:    dout = sel_q;
      2'd1:    dout = idx_q;
      2'd2:    dout = rval[7:0];
      default: dout = rval[15:8];
    endcase
  end

  always_comb begin
    state_d = state_q;  v_d = v_q;
    accl_d  = accl_q;   accr_d = accr_q;
    sl_d    = sl_q;     sr_d = sr_q;
    valid_d = 1'b0;     ovr_d = ovr_q;
    rd_d    = rd_q;     addr_d = addr_q;
    sel_d   = sel_q;    idx_d = idx_q;   hold_d = hold_q;
    run_d   = run_q;    loop_d = loop_q; done_d = done_q; cval_d = cval_q;
    start_d = start_q;  end_d = end_q;   lpa_d = lpa_q;
    step_d  = step_q;   vol_d = vol_q;   pos_d = pos_q;
    tag_d   = tag_q;    word_d = word_q;

    cur_int = pos_q[v_q][PW-1:8];
    lane    = cur_int[1:0];
    smp     = word_q[v_q][{lane, 4'b0000} +: 16];
    smp_x   = {{(AW-8){smp[15]}}, smp};
    vl_x    = {{AW{1'b0}}, vol_q[v_q][7:0]};
    vr_x    = {{AW{1'b0}}, vol_q[v_q][15:8]};
    prod_l  = smp_x * vl_x;
    prod_r  = smp_x * vr_x;
    sum     = {1'b0, pos_q[v_q]} + {{(PW-15){1'b0}}, step_q[v_q]};
    off     = '0;
    off[ADDR_W:0] = {cur_int[ADDR_W-1:2], 3'b000};

    if (sample_tick && state_q != S_IDLE) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: if (sample_tick) begin
        state_d = S_SCAN;
        v_d     = '0;
      end
      S_SCAN: begin
        if (!run_q[v_q]) begin
          if (v_q == LAST_V) state_d = S_OUT;
          else v_d = v_q + VW'(1);
        end else if (!cval_q[v_q] || tag_q[v_q] != cur_int[ADDR_W-1:2]) begin
          state_d = S_REQ;
        end else begin
          state_d = S_MIX;
        end
      end
      S_REQ: begin
        if (!rd_q) begin
          if (!sdram_busy) begin
            rd_d   = 1'b1;
            addr_d = SDRAM_BASE + off;
          end
        end else if (sdram_dout_ready) begin
          word_d[v_q] = sdram_dout;
          tag_d[v_q]  = cur_int[ADDR_W-1:2];
          cval_d[v_q] = 1'b1;
          rd_d        = 1'b0;
          state_d     = S_MIX;
        end
      end
      S_MIX: begin
        accl_d = accl_q + $signed(prod_l[AW+7:8]);
        accr_d = accr_q + $signed(prod_r[AW+7:8]);
        // Passing END either wraps to LOOP (fraction dropped) or retires the voice.
        if (sum[PW:8] > {1'b0, end_q[v_q]}) begin
          if (loop_q[v_q]) begin
            pos_d[v_q] = {lpa_q[v_q], 8'h00};
          end else begin
            pos_d[v_q]  = sum[PW-1:0];
            run_d[v_q]  = 1'b0;
            done_d[v_q] = 1'b1;
          end
        end else begin
          pos_d[v_q] = sum[PW-1:0];
        end
        if (v_q == LAST_V) begin
          state_d = S_OUT;
        end else begin
          v_d     = v_q + VW'(1);
          state_d = S_SCAN;
        end
      end
      S_OUT: begin
        sl_d    = sat16(accl_q);
        sr_d    = sat16(accr_q);
        valid_d = 1'b1;
        accl_d  = '0;
        accr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Host writes come last so they override an engine update of the same voice.
    if (we) begin
      case (addr)
        2'd0: sel_d  = din;
        2'd1: idx_d  = din;
        2'd2: hold_d = din;
        default: if (hv_ok) begin
          case (idx_q[3:0])
            4'd0: begin
              run_d[hv]  = wdata[0];
              loop_d[hv] = wdata[1];
              if (wdata[0]) done_d[hv] = 1'b0;
              if (wdata[0] && !run_q[hv]) begin
                pos_d[hv]  = {start_q[hv], 8'h00};
                cval_d[hv] = 1'b0;
              end
            end
            4'd1: start_d[hv][ADDR_W-1:16] = wdata[ADDR_W-17:0];
            4'd2: start_d[hv][15:0]        = wdata;
            4'd3: end_d[hv][ADDR_W-1:16]   = wdata[ADDR_W-17:0];
            4'd4: end_d[hv][15:0]          = wdata;
            4'd5: lpa_d[hv][ADDR_W-1:16]   = wdata[ADDR_W-17:0];
            4'd6: lpa_d[hv][15:0]          = wdata;
            4'd7: step_d[hv]               = wdata;
            4'd8: vol_d[hv]                = wdata;
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  v_q <= '0;
      accl_q  <= '0;      accr_q <= '0;
      sl_q    <= '0;      sr_q <= '0;
      valid_q <= 1'b0;    ovr_q <= 1'b0;
      rd_q    <= 1'b0;    addr_q <= '0;
      sel_q   <= '0;      idx_q <= '0;   hold_q <= '0;
      run_q   <= '0;      loop_q <= '0;  done_q <= '0; cval_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        lpa_q[i]   <= '0;
        step_q[i]  <= '0;
        vol_q[i]   <= '0;
        pos_q[i]   <= '0;
        tag_q[i]   <= '0;
        word_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;  v_q <= v_d;
      accl_q  <= accl_d;   accr_q <= accr_d;
      sl_q    <= sl_d;     sr_q <= sr_d;
      valid_q <= valid_d;  ovr_q <= ovr_d;
      rd_q    <= rd_d;     addr_q <= addr_d;
      sel_q   <= sel_d;    idx_q <= idx_d;   hold_q <= hold_d;
      run_q   <= run_d;    loop_q <= loop_d; done_q <= done_d; cval_q <= cval_d;
      start_q <= start_d;  end_q <= end_d;   lpa_q <= lpa_d;
      step_q  <= step_d;   vol_q <= vol_d;   pos_q <= pos_d;
      tag_q   <= tag_d;    word_q <= word_d;
    end
  end

  assign sdram_rd     = rd_q;
  assign sdram_addr   = addr_q;
  assign sample_l     = sl_q;
  assign sample_r     = sr_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_ics2115_voice_engine.sv
// Directed bench for ics2115_voice_engine: host register access, playback, looping, mixing,
// saturation, fractional stepping, SDRAM busy handling, overrun and mid-fetch reset.
module tb_ics2115_voice_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        sample_tick = 1'b0;
  logic        sdram_rd;
  logic [28:0] sdram_addr;
  logic [63:0] sdram_dout = '0;
  logic        sdram_busy = 1'b0;
  logic        sdram_dout_ready = 1'b0;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid, overrun;

  always #5 clk = ~clk;

  ics2115_voice_engine dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout), .we(we), .re(re),
    .sample_tick(sample_tick), .sdram_rd(sdram_rd), .sdram_addr(sdram_addr),
    .sdram_dout(sdram_dout), .sdram_busy(sdram_busy), .sdram_dout_ready(sdram_dout_ready),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid), .overrun(overrun)
  );

  logic [63:0] rom [256];
  int          lat_cfg = 3;
  int          busy_cnt = 0;
  int          nreads = 0;
  int          lat = 0;
  int          rd_high_cnt = 0;
  int          nvalid = 0;
  bit          in_flight = 1'b0;
  bit          addr_moved = 1'b0;
  bit          rd_while_busy = 1'b0;
  bit          rd_prev = 1'b0;
  logic [28:0] req_addr = '0;
  logic [28:0] last_rd_addr = '0;
  logic [15:0] last_l = '0, last_r = '0;
  int          tests = 0, fails = 0;

  logic [15:0] lp_l [6] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd4, 16'd6};
  logic [15:0] lp_r [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd2, 16'd3};
  logic [15:0] fr_e [8] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};

  // SDRAM model: fixed latency, not reset, so a late ready can land after a DUT reset.
  always @(negedge clk) begin
    sdram_dout_ready = 1'b0;
    if (sdram_rd && !rd_prev && sdram_busy) rd_while_busy = 1'b1;
    rd_prev = sdram_rd;
    if (sdram_rd) rd_high_cnt++;
    if (busy_cnt > 0) begin
      sdram_busy = 1'b1;
      busy_cnt--;
    end else begin
      sdram_busy = 1'b0;
    end
    if (in_flight) begin
      if (sdram_addr != req_addr) addr_moved = 1'b1;
      lat--;
      if (lat == 0) begin
        sdram_dout       = rom[req_addr[10:3]];
        sdram_dout_ready = 1'b1;
        in_flight        = 1'b0;
      end
    end else if (sdram_rd) begin
      in_flight    = 1'b1;
      lat          = lat_cfg;
      req_addr     = sdram_addr;
      last_rd_addr = sdram_addr;
      nreads++;
    end
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      nvalid++;
      last_l = sample_l;
      last_r = sample_r;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic set_reg(input int vc, input int ix, input logic [15:0] val);
    wr(2'd0, 8'(vc));
    wr(2'd1, 8'(ix));
    wr(2'd2, val[7:0]);
    wr(2'd3, val[15:8]);
  endtask

  task automatic get_reg(input int vc, input int ix, output logic [15:0] val);
    wr(2'd0, 8'(vc));
    wr(2'd1, 8'(ix));
    @(negedge clk);
    re = 1'b1; addr = 2'd2;
    #1 val[7:0] = dout;
    addr = 2'd3;
    #1 val[15:8] = dout;
    re = 1'b0;
  endtask

  task automatic tick_expect(input string tag, input logic [15:0] el, input logic [15:0] er);
    int n0;
    n0 = nvalid;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int i = 0; i < 400 && nvalid == n0; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_valid"}, nvalid - n0, 1);
    chk({tag, "_l"}, last_l, el);
    chk({tag, "_r"}, last_r, er);
  endtask

  initial begin
    logic [15:0] v;
    int n0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h40] = 64'h0004_0003_0002_0001;
    rom[8'h41] = 64'h0008_0007_0006_0005;
    rom[8'h44] = 64'h7000_7000_7000_7000;
    rom[8'h45] = 64'h9000_9000_9000_9000;
    rom[8'h46] = 64'h1000_1000_1000_1000;
    rom[8'h47] = 64'h2000_2000_2000_2000;

    repeat (3) @(negedge clk);
    chk("rst_rd", sdram_rd, 0);
    chk("rst_l", sample_l, 0);
    chk("rst_r", sample_r, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    @(negedge clk);

    set_reg(0, 2, 16'h0100);
    get_reg(0, 2, v);
    chk("start_lo_rb", v, 16'h0100);
    set_reg(0, 1, 16'hFFFF);
    get_reg(0, 1, v);
    chk("start_hi_rb", v, 16'h00FF);
    set_reg(0, 1, 16'h0000);
    set_reg(0, 9, 16'hABCD);
    get_reg(0, 9, v);
    chk("idx9_rd", v, 16'h0000);
    addr = 2'd1;
    #1 chk("ptr_idx", dout, 8'h09);

    // Single voice, START 0x100..END 0x103, unity step and volume
    set_reg(0, 4, 16'h0103);
    set_reg(0, 7, 16'h0100);
    set_reg(0, 8, 16'hFFFF);
    nreads = 0;
    set_reg(0, 0, 16'h0001);
    tick_expect("sv0", 16'h0000, 16'h0000);
    tick_expect("sv1", 16'h0001, 16'h0001);
    tick_expect("sv2", 16'h0002, 16'h0002);
    tick_expect("sv3", 16'h0003, 16'h0003);
    chk("sv_reads", nreads, 1);
    chk("sv_addr", last_rd_addr, 29'h200);
    get_reg(0, 0, v);
    chk("sv_ctrl_done", v, 16'h0004);
    tick_expect("sv_after", 16'h0000, 16'h0000);
    chk("sv_ovr", overrun, 0);

    // Looping voice, step 2, R at half volume
    set_reg(0, 4, 16'h0107);
    set_reg(0, 6, 16'h0104);
    set_reg(0, 7, 16'h0200);
    set_reg(0, 8, 16'h80FF);
    nreads = 0;
    set_reg(0, 0, 16'h0003);
    for (int i = 0; i < 6; i++) tick_expect("loop", lp_l[i], lp_r[i]);
    chk("loop_reads", nreads, 2);
    get_reg(0, 0, v);
    chk("loop_ctrl", v, 16'h0003);
    set_reg(0, 0, 16'h0000);

    // Four voices at full scale, positive then negative saturation
    for (int k = 0; k < 4; k++) begin
      set_reg(k, 2, 16'h0110);
      set_reg(k, 4, 16'h0113);
      set_reg(k, 7, 16'h0100);
      set_reg(k, 8, 16'hFFFF);
      set_reg(k, 0, 16'h0001);
    end
    tick_expect("sat_pos", 16'h7FFF, 16'h7FFF);
    for (int k = 0; k < 4; k++) begin
      set_reg(k, 0, 16'h0000);
      set_reg(k, 2, 16'h0114);
      set_reg(k, 4, 16'h0117);
      set_reg(k, 0, 16'h0001);
    end
    tick_expect("sat_neg", 16'h8000, 16'h8000);
    for (int k = 0; k < 4; k++) set_reg(k, 0, 16'h0000);

    // Two-voice mix without saturation: 0x1000 L-only plus 0x2000 at half volume
    set_reg(0, 2, 16'h0118);
    set_reg(0, 4, 16'h011B);
    set_reg(0, 8, 16'h00FF);
    set_reg(0, 0, 16'h0001);
    set_reg(1, 2, 16'h011C);
    set_reg(1, 4, 16'h011F);
    set_reg(1, 8, 16'h8080);
    set_reg(1, 0, 16'h0001);
    tick_expect("mix2", 16'h1FF0, 16'h1000);
    set_reg(0, 0, 16'h0000);
    set_reg(1, 0, 16'h0000);

    // Half-rate step with SDRAM busy at the start of the fetch
    set_reg(0, 2, 16'h0100);
    set_reg(0, 4, 16'h0103);
    set_reg(0, 7, 16'h0080);
    set_reg(0, 8, 16'hFFFF);
    set_reg(0, 0, 16'h0001);
    nreads = 0;
    rd_while_busy = 1'b0;
    addr_moved = 1'b0;
    busy_cnt = 5;
    for (int i = 0; i < 8; i++) tick_expect("frac", fr_e[i], fr_e[i]);
    chk("frac_reads", nreads, 1);
    chk("frac_addr", last_rd_addr, 29'h200);
    chk("busy_respected", rd_while_busy, 0);
    chk("addr_stable", addr_moved, 0);
    get_reg(0, 0, v);
    chk("frac_ctrl_done", v, 16'h0004);

    // Second tick while the engine is fetching
    set_reg(0, 2, 16'h0103);
    set_reg(0, 7, 16'h0100);
    set_reg(0, 0, 16'h0001);
    lat_cfg = 10;
    chk("ovr_pre", overrun, 0);
    n0 = nvalid;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    #1 chk("ovr_set", overrun, 1);
    for (int i = 0; i < 200 && nvalid == n0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (40) @(negedge clk);
    #1;
    chk("ovr_one_valid", nvalid - n0, 1);
    chk("ovr_sample", last_l, 16'h0003);
    chk("ovr_sticky", overrun, 1);

    // Reset while a fetch is outstanding
    set_reg(0, 2, 16'h0100);
    set_reg(0, 0, 16'h0001);
    lat_cfg = 8;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int i = 0; i < 20 && !sdram_rd; i++) @(negedge clk);
    chk("rst_req_seen", sdram_rd, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rd", sdram_rd, 0);
    chk("rst_mid_addr", sdram_addr, 0);
    chk("rst_mid_l", sample_l, 0);
    chk("rst_mid_ovr", overrun, 0);
    n0 = nvalid;
    rd_high_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("post_rst_valid", nvalid - n0, 0);
    chk("post_rst_rd", rd_high_cnt, 0);
    get_reg(0, 0, v);
    chk("post_rst_ctrl", v, 16'h0000);
    get_reg(0, 2, v);
    chk("post_rst_start", v, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
